// File: rtl/instr_prefetch_buffer.sv
// Sequential instruction prefetcher: fetches words ahead of the CPU into a small
// {pc, instr} FIFO and flushes/refetches whenever the CPU pc leaves the predicted stream.
module instr_prefetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] cpu_pc,
  input  logic        cpu_take,
  output logic [31:0] i_datain,
  output logic        i_hit,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [31:0]        fetch_pc_r;
  logic [31:0]        mem_addr_r;
  logic [31:0]        pc_q_r    [DEPTH];
  logic [31:0]        instr_q_r [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [CNT_W-1:0]   count_r;

  logic               head_valid_s;
  logic [31:0]        exp_pc_s;
  logic               redirect_s;
  logic               pop_s;
  logic               push_s;
  logic               issue_s;

  // Zero-latency hit path from FIFO head, plus the predicted-stream comparison.
  always_comb begin
    head_valid_s = (count_r != {CNT_W{1'b0}});
    i_hit        = head_valid_s && (pc_q_r[rd_ptr_r] == cpu_pc);
    if (i_hit) begin
      i_datain = instr_q_r[rd_ptr_r];
    end else begin
      i_datain = 32'h0000_0000;
    end
    if (head_valid_s) begin
      exp_pc_s = pc_q_r[rd_ptr_r];
    end else if (state_r == BUSY) begin
      exp_pc_s = mem_addr_r;
    end else begin
      exp_pc_s = fetch_pc_r;
    end
    redirect_s = (cpu_pc != exp_pc_s);
    pop_s      = cpu_take && i_hit;
  end

  // Next-state logic; a redirect never issues and suppresses the push of in-flight data.
  always_comb begin
    state_nxt_s = state_r;
    issue_s     = 1'b0;
    push_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (!redirect_s && (count_r < CNT_W'(DEPTH))) begin
          issue_s     = 1'b1;
          state_nxt_s = BUSY;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        if (mem_ack) begin
          push_s      = !redirect_s;
          state_nxt_s = IDLE;
        end else if (redirect_s) begin
          state_nxt_s = FLUSH;
        end else begin
          state_nxt_s = BUSY;
        end
      end
      FLUSH: begin
        if (mem_ack) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = FLUSH;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Memory interface outputs decoded from registered state.
  always_comb begin
    mem_addr = mem_addr_r;
    case (state_r)
      BUSY:    mem_req = 1'b1;
      FLUSH:   mem_req = 1'b1;
      default: mem_req = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Fetch pointer and request address.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_r <= RESET_PC;
      mem_addr_r <= 32'h0000_0000;
    end else begin
      if (redirect_s) begin
        fetch_pc_r <= cpu_pc;
      end else if (push_s) begin
        fetch_pc_r <= fetch_pc_r + 32'd4;
      end
      if (issue_s) begin
        mem_addr_r <= fetch_pc_r;
      end
    end
  end

  // FIFO storage, pointers and occupancy; issue gating on count keeps pushes from overflowing.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        pc_q_r[i]    <= 32'h0000_0000;
        instr_q_r[i] <= 32'h0000_0000;
      end
    end else if (redirect_s) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        pc_q_r[wr_ptr_r]    <= mem_addr_r;
        instr_q_r[wr_ptr_r] <= mem_rdata;
        wr_ptr_r            <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Directed, table-driven bench for instr_prefetch_buffer with a latency-programmable
// memory model returning mem[a] = a + 0x100.
module tb_instr_prefetch_buffer;

  logic        clock;
  logic        reset_n;
  logic [31:0] cpu_pc;
  logic        cpu_take;
  logic [31:0] i_datain;
  logic        i_hit;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_cmp;
  int n_err;
  int lat;
  int wait_cnt;

  typedef struct {
    bit          rst;
    int          lat;
    logic [31:0] pc;
    logic        take;
    logic        hit;
    logic [31:0] data;
    logic        req;
    logic [31:0] addr;
  } vec_t;

  vec_t vq[$];

  instr_prefetch_buffer #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .cpu_pc    (cpu_pc),
    .cpu_take  (cpu_take),
    .i_datain  (i_datain),
    .i_hit     (i_hit),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory model: ack arrives in the lat-th cycle of a request.
  task automatic mem_step();
    if (mem_req) begin
      if (wait_cnt >= lat - 1) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_addr + 32'h0000_0100;
        wait_cnt  = 0;
      end else begin
        mem_ack  = 1'b0;
        wait_cnt = wait_cnt + 1;
      end
    end else begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end
  endtask

  task automatic hold_reset();
    reset_n   = 1'b0;
    #1;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    wait_cnt  = 0;
  endtask

  task automatic step(input logic [31:0] pc, input logic take);
    @(negedge clock);
    reset_n  = 1'b1;
    mem_step();
    cpu_pc   = pc;
    cpu_take = take;
    #1;
  endtask

  function automatic void add(input bit rst, input int l, input logic [31:0] pc, input logic take,
                              input logic hit, input logic [31:0] data, input logic req,
                              input logic [31:0] addr);
    vec_t v;
    v.rst = rst; v.lat = l; v.pc = pc; v.take = take;
    v.hit = hit; v.data = data; v.req = req; v.addr = addr;
    vq.push_back(v);
  endfunction

  initial begin
    n_cmp = 0; n_err = 0; lat = 1; wait_cnt = 0;
    reset_n = 1'b0; cpu_pc = 32'h0; cpu_take = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;

    // Sequential stream, CPU consuming every word (1-cycle memory).
    add(1, 1, 32'h0, 1, 0, 32'h0,   0, 32'h0);
    add(0, 1, 32'h0, 1, 0, 32'h0,   1, 32'h0);
    add(0, 1, 32'h0, 1, 1, 32'h100, 0, 32'h0);
    add(0, 1, 32'h4, 1, 0, 32'h0,   1, 32'h4);
    add(0, 1, 32'h4, 1, 1, 32'h104, 0, 32'h4);
    add(0, 1, 32'h8, 1, 0, 32'h0,   1, 32'h8);
    add(0, 1, 32'h8, 1, 1, 32'h108, 0, 32'h8);
    add(0, 1, 32'hc, 1, 0, 32'h0,   1, 32'hc);
    add(0, 1, 32'hc, 1, 1, 32'h10c, 0, 32'hc);
    // Fill to full with CPU stalled, one take, then jal to 0x80.
    add(1, 1, 32'h0, 0, 0, 32'h0,   0, 32'h0);
    add(0, 1, 32'h0, 0, 0, 32'h0,   1, 32'h0);
    add(0, 1, 32'h0, 0, 1, 32'h100, 0, 32'h0);
    add(0, 1, 32'h0, 0, 1, 32'h100, 1, 32'h4);
    add(0, 1, 32'h0, 0, 1, 32'h100, 0, 32'h4);
    add(0, 1, 32'h0, 0, 1, 32'h100, 1, 32'h8);
    add(0, 1, 32'h0, 0, 1, 32'h100, 0, 32'h8);
    add(0, 1, 32'h0, 0, 1, 32'h100, 1, 32'hc);
    add(0, 1, 32'h0, 0, 1, 32'h100, 0, 32'hc);
    add(0, 1, 32'h0, 0, 1, 32'h100, 0, 32'hc);
    add(0, 1, 32'h0, 1, 1, 32'h100, 0, 32'hc);
    add(0, 1, 32'h4, 0, 1, 32'h104, 0, 32'hc);
    add(0, 1, 32'h4, 0, 1, 32'h104, 1, 32'h10);
    add(0, 1, 32'h4, 0, 1, 32'h104, 0, 32'h10);
    add(0, 1, 32'h4, 0, 1, 32'h104, 0, 32'h10);
    add(0, 1, 32'h80, 0, 0, 32'h0,   0, 32'h10);
    add(0, 1, 32'h80, 0, 0, 32'h0,   0, 32'h10);
    add(0, 1, 32'h80, 0, 0, 32'h0,   1, 32'h80);
    add(0, 1, 32'h80, 0, 1, 32'h180, 0, 32'h80);
    add(0, 1, 32'h80, 0, 1, 32'h180, 1, 32'h84);
    // 3-cycle memory: redirect to 0x10, then j to 0xcc while BUSY.
    add(1, 3, 32'h10, 0, 0, 32'h0,   0, 32'h0);
    add(0, 3, 32'h10, 0, 0, 32'h0,   0, 32'h0);
    add(0, 3, 32'h10, 0, 0, 32'h0,   1, 32'h10);
    add(0, 3, 32'hcc, 0, 0, 32'h0,   1, 32'h10);
    add(0, 3, 32'hcc, 0, 0, 32'h0,   1, 32'h10);
    add(0, 3, 32'hcc, 0, 0, 32'h0,   0, 32'h10);
    add(0, 3, 32'hcc, 0, 0, 32'h0,   1, 32'hcc);
    add(0, 3, 32'hcc, 0, 0, 32'h0,   1, 32'hcc);
    add(0, 3, 32'hcc, 0, 0, 32'h0,   1, 32'hcc);
    add(0, 3, 32'hcc, 0, 1, 32'h1cc, 0, 32'hcc);
    // Address wrap at the top of memory.
    add(1, 1, 32'hFFFF_FFFC, 1, 0, 32'h0,  0, 32'h0);
    add(0, 1, 32'hFFFF_FFFC, 1, 0, 32'h0,  0, 32'h0);
    add(0, 1, 32'hFFFF_FFFC, 1, 0, 32'h0,  1, 32'hFFFF_FFFC);
    add(0, 1, 32'hFFFF_FFFC, 1, 1, 32'hFC, 0, 32'hFFFF_FFFC);
    add(0, 1, 32'h0,         1, 0, 32'h0,  1, 32'h0);
    add(0, 1, 32'h0,         1, 1, 32'h100, 0, 32'h0);

    hold_reset();
    chk("reset mem_req",  {31'h0, mem_req}, 32'h0);
    chk("reset i_hit",    {31'h0, i_hit},   32'h0);
    chk("reset i_datain", i_datain,         32'h0);
    chk("reset mem_addr", mem_addr,         32'h0);

    for (int i = 0; i < vq.size(); i++) begin
      if (vq[i].rst) begin
        hold_reset();
        #3;
      end
      lat = vq[i].lat;
      step(vq[i].pc, vq[i].take);
      chk($sformatf("v%0d i_hit", i),    {31'h0, i_hit},   {31'h0, vq[i].hit});
      chk($sformatf("v%0d i_datain", i), i_datain,         vq[i].data);
      chk($sformatf("v%0d mem_req", i),  {31'h0, mem_req}, {31'h0, vq[i].req});
      chk($sformatf("v%0d mem_addr", i), mem_addr,         vq[i].addr);
    end

    // Asynchronous reset in the middle of a BUSY cycle with a hit present.
    hold_reset();
    #3;
    lat = 3;
    for (int c = 0; c < 6; c++) step(32'h0, 1'b0);
    chk("pre-rst mem_req", {31'h0, mem_req}, 32'h1);
    chk("pre-rst i_hit",   {31'h0, i_hit},   32'h1);
    chk("pre-rst addr",    mem_addr,         32'h4);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async mem_req",  {31'h0, mem_req}, 32'h0);
    chk("async i_hit",    {31'h0, i_hit},   32'h0);
    chk("async i_datain", i_datain,         32'h0);
    mem_ack  = 1'b0;
    wait_cnt = 0;
    lat      = 1;
    step(32'h0, 1'b0);
    chk("post-rst idle req", {31'h0, mem_req}, 32'h0);
    step(32'h0, 1'b0);
    chk("post-rst req",  {31'h0, mem_req}, 32'h1);
    chk("post-rst addr", mem_addr,         32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
